// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between NREQ requesters.
// Each accepted request runs IDLE -> EXEC -> RESP: operands registered, result captured, done pulsed.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int OPW  = 4
) (
    input  logic                CLOCK_50,
    input  logic                nRST,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [DW-1:0]       result,
    output logic                res_neg,
    output logic                res_ovf,
    output logic                res_zero,
    output logic [OPW-1:0]      alu_op,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    input  logic [DW-1:0]       alu_out,
    input  logic                alu_neg,
    input  logic                alu_ovf,
    input  logic                alu_zero
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    int              w_idx;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_done;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_result;
    logic            r_neg;
    logic            r_ovf;
    logic            r_zero;

    // Scan starts one past the last winner so a steady requester cannot starve the others.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        w_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_any && req[IW'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = IW'(w_idx);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_gnt  = '0;
        w_done = '0;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_EXEC;
            S_EXEC: begin
                w_gnt[r_owner] = 1'b1;
                w_next         = S_RESP;
            end
            S_RESP: begin
                w_done[r_owner] = 1'b1;
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            r_last   <= LAST_RST;
            r_owner  <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_owner <= w_pick;
                r_last  <= w_pick;
                r_op    <= req_op[int'(w_pick)*OPW +: OPW];
                r_a     <= req_a[int'(w_pick)*DW +: DW];
                r_b     <= req_b[int'(w_pick)*DW +: DW];
            end
            // The ALU has had the whole EXEC cycle to settle on the registered operands.
            if (r_state == S_EXEC) begin
                r_result <= alu_out;
                r_neg    <= alu_neg;
                r_ovf    <= alu_ovf;
                r_zero   <= alu_zero;
            end
        end
    end

    assign gnt      = w_gnt;
    assign done     = w_done;
    assign result   = r_result;
    assign res_neg  = r_neg;
    assign res_ovf  = r_ovf;
    assign res_zero = r_zero;
    assign alu_op   = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU, transaction-timeline reference model, directed and random stimulus.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]     req    = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [NREQ*DW-1:0]  req_a  = '0;
    logic [NREQ*DW-1:0]  req_b  = '0;
    logic [NREQ-1:0]     gnt, done;
    logic [DW-1:0]       result, alu_a, alu_b, alu_out;
    logic                res_neg, res_ovf, res_zero, alu_neg, alu_ovf, alu_zero;
    logic [OPW-1:0]      alu_op;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
        .CLOCK_50(clk), .nRST(rst_n),
        .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done),
        .result(result), .res_neg(res_neg), .res_ovf(res_ovf), .res_zero(res_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
    );

    // Returns {neg, ovf, zero, result}
    function automatic logic [DW+2:0] alu_fn(input logic [OPW-1:0] op,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          o;
        r = '0;
        o = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            OP_SUB: begin r = a - b; o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            default: r = a ^ b;
        endcase
        return {r[DW-1], o, (r == '0), r};
    endfunction

    assign {alu_neg, alu_ovf, alu_zero, alu_out} = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Reference model: a transaction accepted at clock edge k owns cycle k (gnt) and k+1 (done);
    // the result appears after edge k+1 and the next request may be accepted at edge k+3.
    int              cyc   = 0;
    int              g_cyc = -100;
    int              last  = NREQ - 1;
    int              owner = 0;
    logic [DW+2:0]   pend  = '0;
    logic [DW+2:0]   m_res = '0;
    logic [OPW-1:0]  m_op  = '0;
    logic [DW-1:0]   m_a   = '0;
    logic [DW-1:0]   m_b   = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            g_cyc = -100; last = NREQ - 1; owner = 0;
            pend = '0; m_res = '0; m_op = '0; m_a = '0; m_b = '0;
        end else begin
            cyc++;
            if (cyc == g_cyc + 1) m_res = pend;
            if (cyc >= g_cyc + 3 && req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(last + k) % NREQ]) begin
                        owner = (last + k) % NREQ;
                        break;
                    end
                end
                last  = owner;
                g_cyc = cyc;
                m_op  = req_op[owner*OPW +: OPW];
                m_a   = req_a[owner*DW +: DW];
                m_b   = req_b[owner*DW +: DW];
                pend  = alu_fn(m_op, m_a, m_b);
            end
        end
    end

    initial forever begin
        logic [NREQ-1:0] eg, ed;
        @(negedge clk);
        eg = '0;
        ed = '0;
        if (rst_n && cyc == g_cyc)     eg[owner] = 1'b1;
        if (rst_n && cyc == g_cyc + 1) ed[owner] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("done", 64'(done), 64'(ed));
        chk("gnt_and_done", 64'(gnt & done), 64'd0);
        chk("result", 64'(result), 64'(m_res[DW-1:0]));
        chk("flags", 64'({res_neg, res_ovf, res_zero}), 64'(m_res[DW+2:DW]));
        chk("alu_op", 64'(alu_op), 64'(m_op));
        chk("alu_a", 64'(alu_a), 64'(m_a));
        chk("alu_b", 64'(alu_b), 64'(m_b));
    end

    task automatic set_slot(input int s, input logic [OPW-1:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[s*OPW +: OPW] = op;
        req_a[s*DW +: DW]    = a;
        req_b[s*DW +: DW]    = b;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Full handshake for one slot; returns {neg, ovf, zero, result} seen alongside done.
    task automatic serve(input int s, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output logic [DW+2:0] got);
        bit ok;
        got = '0;
        set_slot(s, op, a, b);
        req[s] = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt[s]) begin ok = 1; break; end
        end
        req[s] = 1'b0;
        if (!ok) timeout("serve_gnt");
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (done[s]) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("serve_done");
        got = {res_neg, res_ovf, res_zero, result};
    endtask

    initial begin
        logic [DW+2:0]   got;
        logic [NREQ-1:0] prev;
        int              ndone, ngnt;
        bit              ok;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_gnt", 64'(gnt), 64'd0);
        rst_n = 1'b1;

        // 1: single ADD on slot 0, exact latency
        set_slot(0, OP_ADD, 32'd5, 32'd7);
        req = 2'b01;
        step();
        chk("t1_gnt", 64'(gnt), 64'h1);
        chk("t1_done_early", 64'(done), 64'h0);
        req = 2'b00;
        step();
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_result", 64'(result), 64'd12);
        chk("t1_zero", 64'(res_zero), 64'd0);
        repeat (2) step();

        // 3: signed overflow on slot 1
        serve(1, OP_ADD, 32'h7FFF_FFFF, 32'h1, got);
        chk("t3_result", 64'(got[DW-1:0]), 64'h8000_0000);
        chk("t3_ovf", 64'(got[DW+1]), 64'd1);
        chk("t3_neg", 64'(got[DW+2]), 64'd1);
        step();

        // 4: zero result, held through idle cycles
        serve(0, OP_SUB, 32'h1234, 32'h1234, got);
        chk("t4_result", 64'(got[DW-1:0]), 64'd0);
        chk("t4_zero", 64'(got[DW]), 64'd1);
        repeat (3) step();
        chk("t4_hold_result", 64'(result), 64'd0);
        chk("t4_hold_zero", 64'(res_zero), 64'd1);

        // 2: both slots held, must alternate, each done with its own sum
        set_slot(0, OP_ADD, 32'd10, 32'd20);
        set_slot(1, OP_ADD, 32'd100, 32'd1);
        req = 2'b11;
        prev = '0;
        ndone = 0;
        for (int i = 0; i < 20 && ndone < 4; i++) begin
            step();
            if (done != '0) begin
                chk("t2_sum", 64'(result), (done == 2'b01) ? 64'd30 : 64'd101);
                if (prev != '0) chk("t2_alternate", 64'(done == prev), 64'd0);
                prev = done;
                ndone++;
            end
        end
        if (ndone < 4) timeout("t2_dones");
        req = 2'b00;
        repeat (3) step();

        // 5: reset during EXEC aborts, then slot 0 first
        set_slot(0, OP_ADD, 32'd1, 32'd2);
        req = 2'b01;
        ok = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt[0]) begin ok = 1; break; end
        end
        if (!ok) timeout("t5_gnt");
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk("t5_gnt_rst", 64'(gnt), 64'd0);
        chk("t5_result_rst", 64'(result), 64'd0);
        chk("t5_alu_a_rst", 64'(alu_a), 64'd0);
        step();
        chk("t5_no_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        req = 2'b11;
        step();
        chk("t5_first_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        repeat (3) step();

        // 6: slot 0 alone, regranted every third cycle
        set_slot(0, OP_OR, 32'hF0, 32'h0F);
        req = 2'b01;
        ngnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt[0]) ngnt++;
        end
        req = 2'b00;
        chk("t6_grants", 64'(ngnt), 64'd4);
        chk("t6_result", 64'(result), 64'hFF);
        repeat (3) step();

        // Random traffic, including boundary operands and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NREQ; s++) begin
                logic [DW-1:0] a, b;
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 5))
                    0: a = 32'h7FFF_FFFF;
                    1: a = 32'h8000_0000;
                    2: b = a;
                    default: ;
                endcase
                set_slot(s, OPW'($urandom_range(0, 3)), a, b);
            end
            req = NREQ'($urandom);
            if (i == 200) rst_n = 1'b0;
            if (i == 202) rst_n = 1'b1;
            step();
        end
        req = '0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
